keypad_scan_ctrl: RTL and testbench

- Controller for the 4x4 keypad matrix: sequences active-low column drive, synchronises and debounces rows, and decodes one key at a time into a 4-bit code.
- Presents each code through a valid/ready handshake to downstream logic (signal-generator control).
- Replaces free-running column rotation with scan/pause/debounce/release sequencing.

---
 rtl/keypad_scan_ctrl.sv | 220 ++++++++++++++++++++++
 tb/tb_keypad_scan_ctrl.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scan_ctrl.sv
// 4x4 keypad scanner: one-cold column drive, synchronised/debounced rows, valid/ready key output.
// Optional auto-repeat while a key is held is enabled by defining KEYPAD_REPEAT_EN.
module keypad_scan_ctrl #(
    parameter int SETTLE_CYC   = 4,
    parameter int DEBOUNCE_CYC = 1000000,
    parameter int REPEAT_CYC   = 25000000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] kpr,
    output logic [3:0] kpc,
    output logic [3:0] key_code,
    output logic       key_valid,
    input  logic       key_ready,
    output logic       key_down,
    output logic       overrun,
    input  logic       overrun_clr
);

    localparam int MaxSd  = (SETTLE_CYC > DEBOUNCE_CYC) ? SETTLE_CYC : DEBOUNCE_CYC;
    localparam int MaxCyc = (MaxSd > REPEAT_CYC) ? MaxSd : REPEAT_CYC;
    localparam int CntW   = $clog2(MaxCyc);

    typedef logic [CntW-1:0] cnt_t;

    localparam cnt_t SettleLast = cnt_t'(SETTLE_CYC - 1);
    localparam cnt_t DebLast    = cnt_t'(DEBOUNCE_CYC - 1);
`ifdef KEYPAD_REPEAT_EN
    localparam cnt_t RepLast    = cnt_t'(REPEAT_CYC - 1);
`endif

    typedef enum logic [2:0] {
        SCAN,
        DEBOUNCE,
        PRESS,
        HOLD,
        RELEASE
    } state_t;

    // Rows and columns share the same one-cold encoding: 0111 -> 0 ... 1110 -> 3.
    function automatic logic [1:0] oneColdIndex(input logic [3:0] pat);
        case (pat)
            4'b0111: oneColdIndex = 2'd0;
            4'b1011: oneColdIndex = 2'd1;
            4'b1101: oneColdIndex = 2'd2;
            default: oneColdIndex = 2'd3;
        endcase
    endfunction

    function automatic logic isOneCold(input logic [3:0] pat);
        case (pat)
            4'b0111, 4'b1011, 4'b1101, 4'b1110: isOneCold = 1'b1;
            default:                            isOneCold = 1'b0;
        endcase
    endfunction

    state_t     state_q, state_d;
    cnt_t       cnt_q, cnt_d;
    logic [3:0] kprMeta_q, kprSync_q;
    logic [3:0] rowPat_q, rowPat_d;
    logic [3:0] kpc_q, kpc_d;
    logic [3:0] keyCode_q, keyCode_d;
    logic       keyValid_q, keyValid_d;
    logic       keyDown_q, keyDown_d;
    logic       overrun_q, overrun_d;
    logic       loadReq;
    logic       overrunSet;
`ifdef KEYPAD_REPEAT_EN
    cnt_t       rep_q, rep_d;
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rowPat_d   = rowPat_q;
        kpc_d      = kpc_q;
        keyCode_d  = keyCode_q;
        keyValid_d = keyValid_q;
        keyDown_d  = keyDown_q;
        overrun_d  = overrun_q;
        loadReq    = 1'b0;
        overrunSet = 1'b0;
`ifdef KEYPAD_REPEAT_EN
        rep_d      = rep_q;
`endif

        case (state_q)
            SCAN: begin
                if (cnt_q == SettleLast) begin
                    cnt_d = '0;
                    if (isOneCold(kprSync_q)) begin
                        rowPat_d = kprSync_q;
                        state_d  = DEBOUNCE;
                    end else begin
                        kpc_d = {kpc_q[0], kpc_q[3:1]};
                    end
                end else begin
                    cnt_d = cnt_q + cnt_t'(1);
                end
            end
            DEBOUNCE: begin
                // A mismatch drops back to SCAN on the same column so it re-settles.
                if (kprSync_q == rowPat_q) begin
                    if (cnt_q == DebLast) begin
                        cnt_d   = '0;
                        state_d = PRESS;
                    end else begin
                        cnt_d = cnt_q + cnt_t'(1);
                    end
                end else begin
                    cnt_d   = '0;
                    state_d = SCAN;
                end
            end
            PRESS: begin
                loadReq   = 1'b1;
                keyDown_d = 1'b1;
                state_d   = HOLD;
`ifdef KEYPAD_REPEAT_EN
                rep_d     = '0;
`endif
            end
            HOLD: begin
                if (kprSync_q == 4'b1111) begin
                    cnt_d   = '0;
                    state_d = RELEASE;
                end
`ifdef KEYPAD_REPEAT_EN
                else if (kprSync_q == rowPat_q) begin
                    if (rep_q == RepLast) begin
                        loadReq = 1'b1;
                        rep_d   = '0;
                    end else begin
                        rep_d = rep_q + cnt_t'(1);
                    end
                end
`endif
            end
            RELEASE: begin
`ifdef KEYPAD_REPEAT_EN
                rep_d = '0;
`endif
                if (kprSync_q == 4'b1111) begin
                    if (cnt_q == DebLast) begin
                        keyDown_d = 1'b0;
                        kpc_d     = {kpc_q[0], kpc_q[3:1]};
                        cnt_d     = '0;
                        state_d   = SCAN;
                    end else begin
                        cnt_d = cnt_q + cnt_t'(1);
                    end
                end else begin
                    state_d = HOLD;
                end
            end
            default: begin
                state_d = SCAN;
                cnt_d   = '0;
            end
        endcase

        // A load on the same edge as a consume keeps key_valid high with the new code.
        if (keyValid_q && key_ready) begin
            keyValid_d = 1'b0;
        end
        if (loadReq) begin
            if (!keyValid_q || key_ready) begin
                keyCode_d  = {oneColdIndex(rowPat_q), oneColdIndex(kpc_q)};
                keyValid_d = 1'b1;
            end else begin
                overrunSet = 1'b1;
            end
        end

        if (overrun_clr) begin
            overrun_d = 1'b0;
        end else if (overrunSet) begin
            overrun_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= SCAN;
            cnt_q      <= '0;
            kprMeta_q  <= 4'b1111;
            kprSync_q  <= 4'b1111;
            rowPat_q   <= 4'b1111;
            kpc_q      <= 4'b0111;
            keyCode_q  <= 4'd0;
            keyValid_q <= 1'b0;
            keyDown_q  <= 1'b0;
            overrun_q  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
            rep_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            kprMeta_q  <= kpr;
            kprSync_q  <= kprMeta_q;
            rowPat_q   <= rowPat_d;
            kpc_q      <= kpc_d;
            keyCode_q  <= keyCode_d;
            keyValid_q <= keyValid_d;
            keyDown_q  <= keyDown_d;
            overrun_q  <= overrun_d;
`ifdef KEYPAD_REPEAT_EN
            rep_q      <= rep_d;
`endif
        end
    end

    assign kpc       = kpc_q;
    assign key_code  = keyCode_q;
    assign key_valid = keyValid_q;
    assign key_down  = keyDown_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Scoreboard bench for keypad_scan_ctrl: a keypad-matrix model drives rows from the column outputs,
// expected key codes are queued at stimulus time and popped by a monitor on each new key_valid presentation.
module tb_keypad_scan_ctrl;

    localparam int SettleCyc   = 3;
    localparam int DebounceCyc = 4;
    localparam int RepeatCyc   = 8;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] kpr;
    logic [3:0] kpc;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_ready = 1'b0;
    logic       key_down;
    logic       overrun;
    logic       overrun_clr = 1'b0;

    logic       keyHeld = 1'b0;
    logic [1:0] keyRow = 2'd0;
    logic [1:0] keyCol = 2'd0;
    logic       useRaw = 1'b0;
    logic [3:0] rawKpr = 4'b1111;

    int         passCount = 0;
    int         checkCount = 0;
    logic [3:0] expQ[$];

    logic       prevValid = 1'b0;
    logic       prevAccept = 1'b0;

    keypad_scan_ctrl #(
        .SETTLE_CYC  (SettleCyc),
        .DEBOUNCE_CYC(DebounceCyc),
        .REPEAT_CYC  (RepeatCyc)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .kpr        (kpr),
        .kpc        (kpc),
        .key_code   (key_code),
        .key_valid  (key_valid),
        .key_ready  (key_ready),
        .key_down   (key_down),
        .overrun    (overrun),
        .overrun_clr(overrun_clr)
    );

    always #5 clk = ~clk;

    // A held key pulls its row low only while its column is being driven.
    always_comb begin
        kpr = 4'b1111;
        if (useRaw) begin
            kpr = rawKpr;
        end else if (keyHeld && (kpc[2'd3 - keyCol] == 1'b0)) begin
            kpr[2'd3 - keyRow] = 1'b0;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %0h, required %0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic held, input logic [1:0] row, input logic [1:0] col);
        keyRow  = row;
        keyCol  = col;
        keyHeld = held;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // which: 0 = key_valid, 1 = key_down
    task automatic waitSignal(input string name, input int which, input logic level, input int budget);
        int n = 0;
        while ((((which == 0) ? key_valid : key_down) !== level) && (n < budget)) begin
            tick(1);
            n++;
        end
        if ((((which == 0) ? key_valid : key_down) !== level)) begin
            checkOutput({name, "Timeout"}, 32'd0, 32'd1);
        end
    endtask

    task automatic waitKpc(input string name, input logic [3:0] pat, input logic equal, input int budget);
        int n = 0;
        while (((kpc == pat) != equal) && (n < budget)) begin
            tick(1);
            n++;
        end
        if ((kpc == pat) != equal) begin
            checkOutput({name, "Timeout"}, 32'd0, 32'd1);
        end
    endtask

    // Monitor: every fresh key presentation must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!reset_n) begin
            prevValid  <= 1'b0;
            prevAccept <= 1'b0;
        end else begin
            if (key_valid && (!prevValid || prevAccept)) begin
                if (expQ.size() == 0) begin
                    checkCount++;
                    $display("[TB] FAIL unexpectedKey: got %0d, required no key", key_code);
                end else begin
                    checkOutput("keyCode", {28'd0, key_code}, {28'd0, expQ.pop_front()});
                end
            end
            prevValid  <= key_valid;
            prevAccept <= key_valid && key_ready;
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [3:0] colSeq[4];
        logic       validSeen;
        logic       downSeen;
        int         changes;
        logic [3:0] lastKpc;

        colSeq[0] = 4'b1011;
        colSeq[1] = 4'b1101;
        colSeq[2] = 4'b1110;
        colSeq[3] = 4'b0111;

        $display("[TB] reset and idle scan");
        tick(3);
        checkOutput("resetKpc", kpc, 4'b0111);
        checkOutput("resetValid", key_valid, 1'b0);
        checkOutput("resetDown", key_down, 1'b0);
        checkOutput("resetOverrun", overrun, 1'b0);
        checkOutput("resetCode", key_code, 4'd0);
        reset_n = 1'b1;
        tick(2);
        checkOutput("scanHold", kpc, 4'b0111);
        tick(1);
        checkOutput("scanOrder", kpc, colSeq[0]);
        for (int i = 1; i < 4; i++) begin
            tick(3);
            checkOutput("scanOrder", kpc, colSeq[i]);
        end

        $display("[TB] single press key 9");
        expQ.push_back(4'd9);
        applyStimulus(1'b1, 2'd2, 2'd1);
        waitSignal("pressValid", 0, 1'b1, 200);
        checkOutput("pressDown", key_down, 1'b1);
        key_ready = 1'b1;
        tick(1);
        key_ready = 1'b0;
        checkOutput("readyClears", key_valid, 1'b0);
        applyStimulus(1'b0, 2'd2, 2'd1);
        tick(6);
        checkOutput("releaseHold", key_down, 1'b1);
        tick(1);
        checkOutput("releaseDone", key_down, 1'b0);
        checkOutput("resumeColumn", kpc, 4'b1101);

        $display("[TB] bounce on column 3");
        waitKpc("bounceCol", 4'b1110, 1'b1, 50);
        validSeen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            applyStimulus((i % 2) == 0, 2'd3, 2'd3);
            tick(1);
            if (key_valid) validSeen = 1'b1;
            tick(1);
            if (key_valid) validSeen = 1'b1;
        end
        checkOutput("bounceNoKey", validSeen, 1'b0);
        expQ.push_back(4'd15);
        applyStimulus(1'b1, 2'd3, 2'd3);
        waitSignal("stableValid", 0, 1'b1, 200);
        key_ready = 1'b1;
        tick(1);
        key_ready = 1'b0;
        applyStimulus(1'b0, 2'd3, 2'd3);
        waitSignal("stableRelease", 1, 1'b0, 50);

        $display("[TB] multiple rows low");
        useRaw = 1'b1;
        rawKpr = 4'b0011;
        validSeen = 1'b0;
        downSeen = 1'b0;
        changes = 0;
        lastKpc = kpc;
        for (int i = 0; i < 36; i++) begin
            tick(1);
            if (key_valid) validSeen = 1'b1;
            if (key_down) downSeen = 1'b1;
            if (kpc != lastKpc) changes++;
            lastKpc = kpc;
        end
        checkOutput("multiNoKey", validSeen, 1'b0);
        checkOutput("multiNoDown", downSeen, 1'b0);
        checkOutput("multiScans", changes >= 8, 1'b1);
        useRaw = 1'b0;
        rawKpr = 4'b1111;

        $display("[TB] overrun");
        expQ.push_back(4'd0);
        applyStimulus(1'b1, 2'd0, 2'd0);
        waitSignal("key0Valid", 0, 1'b1, 200);
        applyStimulus(1'b0, 2'd0, 2'd0);
        waitSignal("key0Release", 1, 1'b0, 50);
        applyStimulus(1'b1, 2'd1, 2'd1);
        waitSignal("key5Down", 1, 1'b1, 200);
        checkOutput("overrunSet", overrun, 1'b1);
        checkOutput("overrunValid", key_valid, 1'b1);
        checkOutput("overrunKeepCode", key_code, 4'd0);
        applyStimulus(1'b0, 2'd1, 2'd1);
        waitSignal("key5Release", 1, 1'b0, 50);
        checkOutput("overrunSticky", overrun, 1'b1);
        overrun_clr = 1'b1;
        applyStimulus(1'b1, 2'd1, 2'd1);
        waitSignal("clrPressDown", 1, 1'b1, 200);
        checkOutput("clrPriority", overrun, 1'b0);
        overrun_clr = 1'b0;
        tick(1);
        checkOutput("clrStays", overrun, 1'b0);
        applyStimulus(1'b0, 2'd1, 2'd1);
        waitSignal("clrRelease", 1, 1'b0, 50);
        applyStimulus(1'b1, 2'd1, 2'd1);
        waitSignal("againDown", 1, 1'b1, 200);
        checkOutput("overrunAgain", overrun, 1'b1);
        applyStimulus(1'b0, 2'd1, 2'd1);
        waitSignal("againRelease", 1, 1'b0, 50);

        $display("[TB] reset during debounce");
        waitKpc("leaveCol2", 4'b1101, 1'b0, 50);
        waitKpc("reachCol2", 4'b1101, 1'b1, 50);
        applyStimulus(1'b1, 2'd0, 2'd2);
        tick(5);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("midResetKpc", kpc, 4'b0111);
        checkOutput("midResetValid", key_valid, 1'b0);
        checkOutput("midResetDown", key_down, 1'b0);
        checkOutput("midResetOverrun", overrun, 1'b0);
        checkOutput("midResetCode", key_code, 4'd0);
        applyStimulus(1'b0, 2'd0, 2'd2);
        tick(2);
        reset_n = 1'b1;
        tick(40);
        checkOutput("discardValid", key_valid, 1'b0);
        checkOutput("discardDown", key_down, 1'b0);

`ifdef KEYPAD_REPEAT_EN
        $display("[TB] auto-repeat key 6");
        key_ready = 1'b1;
        for (int i = 0; i < 4; i++) expQ.push_back(4'd6);
        applyStimulus(1'b1, 2'd1, 2'd2);
        waitSignal("repeatValid", 0, 1'b1, 200);
        tick(24);
        applyStimulus(1'b0, 2'd1, 2'd2);
        waitSignal("repeatRelease", 1, 1'b0, 100);
        tick(20);
        key_ready = 1'b0;
`endif

        checkOutput("queueDrained", expQ.size(), 32'd0);
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
